// File: rtl/stepper_motion_ctrl.sv
// ---------------------------------------------------------------------------
// stepper_motion_ctrl
// Motion sequencer in front of a full-step bipolar stepper driver. It accepts
// absolute-position and homing commands over a valid/ready handshake. It then
// issues single-cycle step requests spaced P_STEP_DIV cycles apart, tracks the
// commanded position, and reports done/error.
//
// Ports
//   i_clk, i_rst_n   clock (shared with the driver), async active-low reset
//   i_cmd_valid      command present
//   o_cmd_ready      high only in IDLE; accept = valid && ready
//   i_cmd_home       1 = homing command (target ignored)
//   i_cmd_target     absolute target position 0..P_COUNT_LIMIT
//   i_abort          level; stops motion (ignored in IDLE)
//   i_pos_stat       driver status: 00 home, 01 at limit, 10 between
//   o_control        bit0 forward request, bit1 reverse request, bits3:2 = 0
//   o_position       commanded position counter
//   o_busy           high in every state except IDLE
//   o_done           1-cycle pulse on successful completion
//   o_err            1-cycle pulse on rejected command or homing timeout
// ---------------------------------------------------------------------------
module stepper_motion_ctrl #(
    parameter int P_COUNT_LIMIT  = 200,
    parameter int P_STEP_DIV     = 4,
    parameter int P_HOME_TIMEOUT = 204
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_home,
    input  logic [7:0] i_cmd_target,
    input  logic       i_abort,
    input  logic [1:0] i_pos_stat,
    output logic [3:0] o_control,
    output logic [7:0] o_position,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam logic [7:0]  LIMIT    = 8'(P_COUNT_LIMIT);
    // STEP occupies one cycle and WAIT ends on the cycle where the divider
    // reads zero, so loading P_STEP_DIV-2 gives exactly P_STEP_DIV cycles.
    localparam logic [15:0] DIV_LOAD = 16'(P_STEP_DIV - 2);
    localparam logic [15:0] HOME_TO  = 16'(P_HOME_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_STEP   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [7:0]  target_q, target_d;
    logic        home_q,   home_d;
    logic        dir_q,    dir_d;      // 1 = forward
    logic [7:0]  pos_q,    pos_d;
    logic [15:0] div_q,    div_d;
    logic [15:0] hcnt_q,   hcnt_d;
    logic        err_q,    err_d;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            target_q <= 8'd0;
            home_q   <= 1'b0;
            dir_q    <= 1'b0;
            pos_q    <= 8'd0;
            div_q    <= 16'd0;
            hcnt_q   <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            home_q   <= home_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) state_d = S_CHECK;
                else             state_d = S_IDLE;
            end
            S_CHECK: begin
                if (i_abort)                 state_d = S_IDLE;
                else if (home_q)             state_d = S_STEP;
                else if (target_q > LIMIT)   state_d = S_IDLE;
                else if (target_q == pos_q)  state_d = S_FINISH;
                else                         state_d = S_STEP;
            end
            S_STEP: begin
                if (i_abort) state_d = S_IDLE;
                else         state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_abort)                    state_d = S_IDLE;
                else if (div_q != 16'd0)        state_d = S_WAIT;
                else if (home_q) begin
                    if (i_pos_stat == 2'b00)    state_d = S_FINISH;
                    else if (hcnt_q == HOME_TO) state_d = S_IDLE;
                    else                        state_d = S_STEP;
                end else begin
                    if (pos_q == target_q)      state_d = S_FINISH;
                    else                        state_d = S_STEP;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values: command latch, position, divider, homing counter
    always_comb begin
        target_d = target_q;
        home_d   = home_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    target_d = i_cmd_target;
                    home_d   = i_cmd_home;
                end else begin
                    target_d = target_q;
                end
            end
            S_CHECK: begin
                if (home_q) begin
                    dir_d  = 1'b0;
                    hcnt_d = 16'd0;
                end else begin
                    dir_d = (target_q > pos_q);
                    err_d = !i_abort && (target_q > LIMIT);
                end
            end
            S_STEP: begin
                // The request goes out this cycle even under abort, so the
                // count is updated unconditionally.
                if (home_q)     hcnt_d = hcnt_q + 16'd1;
                else if (dir_q) pos_d  = pos_q + 8'd1;
                else            pos_d  = pos_q - 8'd1;
                div_d = DIV_LOAD;
            end
            S_WAIT: begin
                if (div_q != 16'd0) begin
                    div_d = div_q - 16'd1;
                end else if (!i_abort && home_q) begin
                    if (i_pos_stat == 2'b00)    pos_d = 8'd0;
                    else if (hcnt_q == HOME_TO) err_d = 1'b1;
                    else                        pos_d = pos_q;
                end else begin
                    div_d = div_q;
                end
            end
            S_FINISH: begin
                pos_d = pos_q;
            end
            default: begin
                pos_d = pos_q;
            end
        endcase
    end

    // Output decode from the state register
    always_comb begin
        o_control   = 4'b0000;
        o_cmd_ready = (state_q == S_IDLE);
        o_busy      = (state_q != S_IDLE);
        o_done      = 1'b0;
        if (state_q == S_STEP) begin
            o_control = dir_q ? 4'b0001 : 4'b0010;
        end else begin
            o_control = 4'b0000;
        end
        // An abort seen in FINISH suppresses the completion pulse.
        if (state_q == S_FINISH) o_done = !i_abort;
        else                     o_done = 1'b0;
    end

    assign o_position = pos_q;
    assign o_err      = err_q;

endmodule
